riscv_ex_wb_buffer: RTL and testbench

Two-entry result skid buffer between the basic ALU (EX stage) and register-file write-back (WB). It captures ALU results with their destination address and resolves conditional branches from the ALU comparison bit. It also offers a forwarding lookup over buffered results. Its ready output drives the ALU's `ex_ready_i`, so EX never sees a combinational path from WB back-pressure.

---
 rtl/riscv_ex_wb_buffer.sv | 135 +++++++++++++
 tb/tb_riscv_ex_wb_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_wb_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_ex_wb_buffer : two-entry EX->WB result skid buffer with forwarding   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module riscv_ex_wb_buffer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [DATA_WIDTH-1:0] ex_result_i,
    input  logic                  ex_cmp_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic                  ex_we_i,
    input  logic                  ex_branch_i,
    output logic                  branch_taken_o,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_WIDTH-1:0] wb_result_o,
    output logic [ADDR_WIDTH-1:0] wb_waddr_o,
    input  logic [ADDR_WIDTH-1:0] fwd_raddr_i,
    output logic                  fwd_hit_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic [1:0]            occupancy_o
);

    localparam logic [1:0] C_FULL = 2'd2;

    logic [DATA_WIDTH-1:0] result_q [2];
    logic [DATA_WIDTH-1:0] result_d [2];
    logic [ADDR_WIDTH-1:0] waddr_q  [2];
    logic [ADDR_WIDTH-1:0] waddr_d  [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  branch_taken_q, branch_taken_d;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_young_idx;
    logic w_old_idx;
    logic w_hit_young;
    logic w_hit_old;

    assign ex_ready_o  = (count_q != C_FULL);
    assign wb_valid_o  = (count_q != 2'd0);
    assign w_accept    = ex_valid_i & ex_ready_o;
    assign w_push      = w_accept & ex_we_i & ~ex_branch_i & (ex_waddr_i != '0);
    assign w_pop       = wb_valid_o & wb_ready_i;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            result_d[i] = result_q[i];
            waddr_d[i]  = waddr_q[i];
        end
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        branch_taken_d = w_accept & ex_branch_i & ex_cmp_i & ~kill_i;

        if (kill_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_push) begin
                result_d[wr_ptr_q] = ex_result_i;
                waddr_d[wr_ptr_q]  = ex_waddr_i;
                wr_ptr_d           = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                waddr_q[i]  <= '0;
            end
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            branch_taken_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= result_d[i];
                waddr_q[i]  <= waddr_d[i];
            end
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign wb_result_o    = result_q[rd_ptr_q];
    assign wb_waddr_o     = waddr_q[rd_ptr_q];
    assign branch_taken_o = branch_taken_q;
    assign occupancy_o    = count_q;

    // Youngest entry sits just behind the write pointer; the older one only exists when full.
    assign w_young_idx = ~wr_ptr_q;
    assign w_old_idx   = wr_ptr_q;
    assign w_hit_young = (count_q != 2'd0) && (waddr_q[w_young_idx] == fwd_raddr_i);
    assign w_hit_old   = (count_q == C_FULL) && (waddr_q[w_old_idx] == fwd_raddr_i);

    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_raddr_i != '0) begin
            if (w_hit_young) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = result_q[w_young_idx];
            end else if (w_hit_old) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = result_q[w_old_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_ex_wb_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_ex_wb_buffer : scoreboard bench for riscv_ex_wb_buffer            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_riscv_ex_wb_buffer;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kill_i = 1'b0;
    logic          ex_valid_i = 1'b0;
    logic          ex_ready_o;
    logic [DW-1:0] ex_result_i = '0;
    logic          ex_cmp_i = 1'b0;
    logic [AW-1:0] ex_waddr_i = '0;
    logic          ex_we_i = 1'b0;
    logic          ex_branch_i = 1'b0;
    logic          branch_taken_o;
    logic          wb_valid_o;
    logic          wb_ready_i = 1'b0;
    logic [DW-1:0] wb_result_o;
    logic [AW-1:0] wb_waddr_o;
    logic [AW-1:0] fwd_raddr_i = '0;
    logic          fwd_hit_o;
    logic [DW-1:0] fwd_data_o;
    logic [1:0]    occupancy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [AW-1:0] waddr;
    } entry_t;

    entry_t sb[$];

    riscv_ex_wb_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .kill_i         (kill_i),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_result_i    (ex_result_i),
        .ex_cmp_i       (ex_cmp_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_we_i        (ex_we_i),
        .ex_branch_i    (ex_branch_i),
        .branch_taken_o (branch_taken_o),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_result_o    (wb_result_o),
        .wb_waddr_o     (wb_waddr_o),
        .fwd_raddr_i    (fwd_raddr_i),
        .fwd_hit_o      (fwd_hit_o),
        .fwd_data_o     (fwd_data_o),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one EX operation for one cycle; the expected WB entry is queued when it should enqueue.
    task automatic ex_op(input logic [DW-1:0] res, input logic [AW-1:0] wa,
                         input logic we, input logic br, input logic cmp, input logic kill);
        ex_valid_i  = 1'b1;
        ex_result_i = res;
        ex_waddr_i  = wa;
        ex_we_i     = we;
        ex_branch_i = br;
        ex_cmp_i    = cmp;
        kill_i      = kill;
        if (kill) sb.delete();
        else if (ex_ready_o && we && !br && wa != '0) sb.push_back('{result: res, waddr: wa});
        tick();
        ex_valid_i = 1'b0;
        kill_i     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  {63'd0, ex_ready_o},     64'd1);
        chk({tag, "_valid"},  {63'd0, wb_valid_o},     64'd0);
        chk({tag, "_result"}, {32'd0, wb_result_o},    64'd0);
        chk({tag, "_waddr"},  {58'd0, wb_waddr_o},     64'd0);
        chk({tag, "_branch"}, {63'd0, branch_taken_o}, 64'd0);
        chk({tag, "_hit"},    {63'd0, fwd_hit_o},      64'd0);
        chk({tag, "_fdata"},  {32'd0, fwd_data_o},     64'd0);
        chk({tag, "_occ"},    {62'd0, occupancy_o},    64'd0);
    endtask

    // Monitor: every WB pop is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !kill_i && wb_valid_o && wb_ready_i) begin
            entry_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected_pop: got result 0x%0h waddr %0d expected no entry",
                         wb_result_o, wb_waddr_o);
            end else begin
                e = sb.pop_front();
                chk("wb_result", {32'd0, wb_result_o}, {32'd0, e.result});
                chk("wb_waddr",  {58'd0, wb_waddr_o},  {58'd0, e.waddr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fwd_raddr_i = 6'd3;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Empty, single write.
        wb_ready_i = 1'b1;
        ex_op(32'hAA, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_valid", {63'd0, wb_valid_o}, 64'd1);
        chk("single_occ", {62'd0, occupancy_o}, 64'd1);
        tick();
        chk("single_drain_occ", {62'd0, occupancy_o}, 64'd0);

        // Fill under back-pressure, youngest forwarding.
        wb_ready_i = 1'b0;
        ex_op(32'h11, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill1_ready", {63'd0, ex_ready_o}, 64'd1);
        ex_op(32'h22, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill2_ready", {63'd0, ex_ready_o}, 64'd0);
        chk("fill2_occ", {62'd0, occupancy_o}, 64'd2);
        fwd_raddr_i = 6'd3;
        #1;
        chk("fwd_young_hit", {63'd0, fwd_hit_o}, 64'd1);
        chk("fwd_young_data", {32'd0, fwd_data_o}, 64'h22);
        fwd_raddr_i = 6'd4;
        #1;
        chk("fwd_miss_hit", {63'd0, fwd_hit_o}, 64'd0);
        chk("fwd_miss_data", {32'd0, fwd_data_o}, 64'd0);
        ex_op(32'h33, 6'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_result", {32'd0, wb_result_o}, 64'h11);
        chk("stall_occ", {62'd0, occupancy_o}, 64'd2);
        wb_ready_i = 1'b1;
        tick();
        chk("drain_ready", {63'd0, ex_ready_o}, 64'd1);
        chk("drain_occ", {62'd0, occupancy_o}, 64'd1);
        tick();
        chk("drain_empty", {62'd0, occupancy_o}, 64'd0);

        // Branches: taken pulse for one cycle, not-taken no pulse.
        ex_op(32'h55, 6'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("br_taken", {63'd0, branch_taken_o}, 64'd1);
        chk("br_occ", {62'd0, occupancy_o}, 64'd0);
        tick();
        chk("br_pulse_end", {63'd0, branch_taken_o}, 64'd0);
        ex_op(32'h56, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br_not_taken", {63'd0, branch_taken_o}, 64'd0);

        // x0 and non-writing ops.
        ex_op(32'h77, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("x0_occ", {62'd0, occupancy_o}, 64'd0);
        ex_op(32'h88, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nowe_valid", {63'd0, wb_valid_o}, 64'd0);
        fwd_raddr_i = 6'd0;
        #1;
        chk("fwd_x0_hit", {63'd0, fwd_hit_o}, 64'd0);

        // Simultaneous push and pop at count 1.
        wb_ready_i = 1'b0;
        ex_op(32'hA1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_ready_i = 1'b1;
        ex_op(32'hA2, 6'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pp_occ", {62'd0, occupancy_o}, 64'd1);
        fwd_raddr_i = 6'd11;
        #1;
        chk("pp_fwd_hit", {63'd0, fwd_hit_o}, 64'd1);
        chk("pp_fwd_data", {32'd0, fwd_data_o}, 64'hA2);
        fwd_raddr_i = 6'd10;
        #1;
        chk("pp_fwd_gone", {63'd0, fwd_hit_o}, 64'd0);
        tick();
        chk("pp_empty", {62'd0, occupancy_o}, 64'd0);

        // Kill at full, then kill with a concurrent branch accept and enqueue.
        wb_ready_i = 1'b0;
        ex_op(32'hB1, 6'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_op(32'hB2, 6'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_op(32'hB3, 6'd14, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("kill_full_occ", {62'd0, occupancy_o}, 64'd0);
        chk("kill_full_ready", {63'd0, ex_ready_o}, 64'd1);
        ex_op(32'hC1, 6'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_op(32'hC9, 6'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("kill_br_pulse", {63'd0, branch_taken_o}, 64'd0);
        chk("kill_br_occ", {62'd0, occupancy_o}, 64'd0);
        ex_op(32'hC2, 6'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("kill_push_occ", {62'd0, occupancy_o}, 64'd0);

        // Async reset mid-stream with an entry and a pending pulse.
        ex_op(32'hD1, 6'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_op(32'hD2, 6'd21, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_pulse", {63'd0, branch_taken_o}, 64'd1);
        fwd_raddr_i = 6'd20;
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs("async_rst");
        tick();
        rst = 1'b0;
        tick();

        // Recovery after reset.
        wb_ready_i = 1'b1;
        ex_op(32'hE1, 6'd22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("recover_valid", {63'd0, wb_valid_o}, 64'd1);
        repeat (3) tick();
        chk("sb_empty", {32'd0, sb.size()}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
